spi_flash_stream_reader: RTL and testbench

//  SPI mode-0 master that streams a byte range out of the frame-data flash using READ (0x03).

---
 rtl/spi_flash_stream_reader_pkg.sv | 21 ++
 rtl/spi_flash_stream_reader_if.sv | 39 +++
 rtl/spi_flash_stream_reader_holding_reg.sv | 46 ++++
 rtl/spi_flash_stream_reader.sv | 188 ++++++++++++++++++
 tb/tb_spi_flash_stream_reader.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_flash_stream_reader_pkg.sv
// Shared definitions for the SPI flash stream reader: FSM state encoding,
// default READ opcode and command-phase geometry.
package spi_flash_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // READ opcode of the frame-data flash
  localparam logic [7:0] READ_CMD_DEFAULT = 8'h03;

  // Opcode plus 24-bit address
  localparam int CMD_BITS = 32;

  // Receive-bit count that marks a complete byte sitting in the shifter
  localparam logic [3:0] BYTE_FULL = 4'd8;

endpackage

// File: rtl/spi_flash_stream_reader_if.sv
// Request/status and byte-stream signals between the flash reader and its
// controller/consumer. The reader owns the master modport.
interface spi_flash_stream_reader_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 16
);

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  start_len;
  logic              busy;
  logic              done;
  logic [7:0]        data_out;
  logic              data_valid;
  logic              data_ready;

  modport master (
    input  start,
    input  start_addr,
    input  start_len,
    output busy,
    output done,
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    output start,
    output start_addr,
    output start_len,
    input  busy,
    input  done,
    input  data_out,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/spi_flash_stream_reader_holding_reg.sv
// One-entry valid/ready output register. can_load is high when the entry is
// empty or is being consumed this cycle, so a new byte can replace the old
// one without a bubble.
module spi_byte_holding_reg (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       ready,
  output logic [7:0] data,
  output logic       full,
  output logic       can_load
);

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  // Consume on valid&ready, then let a same-cycle load take priority
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end
  end

  // Holding register state
  always_ff @(posedge clk_in) begin
    if (rst) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data     = data_q;
  assign full     = valid_q;
  assign can_load = !valid_q || ready;

endmodule

// File: rtl/spi_flash_stream_reader.sv
// SPI mode-0 master streaming a byte range out of the frame-data flash with
// the READ command. SCLK edges are paced by external divider strobes; a full
// byte in the shifter with the output register occupied holds SCLK low.
// ADDR_W must be 24 so that {opcode, address} fills the 32-bit command word.
module spi_flash_stream_reader
  import spi_flash_stream_reader_pkg::*;
#(
  parameter int         ADDR_W   = 24,
  parameter int         LEN_W    = 16,
  parameter logic [7:0] READ_CMD = READ_CMD_DEFAULT
) (
  input  logic                             clk_in,
  input  logic                             rst,
  input  logic                             tick_rise,
  input  logic                             tick_fall,
  spi_flash_stream_reader_if.master        bus,
  output logic                             spi_cs_n,
  output logic                             spi_sclk,
  output logic                             spi_mosi,
  input  logic                             spi_miso
);

  localparam logic [5:0] LAST_CMD_BIT = 6'(CMD_BITS - 1);

  state_e              state_q, state_d;
  logic                cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CMD_BITS-1:0] cmd_sr_q, cmd_sr_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          rx_sr_q, rx_sr_d;
  logic [3:0]          rx_cnt_q, rx_cnt_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;

  logic                bit_edge;
  logic                rise_ok;
  logic                byte_done;
  logic [7:0]          byte_now;
  logic                hold_load;
  logic                hold_can_load;
  logic                hold_full;
  logic [7:0]          hold_data;

  // A bit edge is the falling half of an SCLK pulse; tick_fall beats tick_rise
  assign bit_edge = tick_fall && sclk_q;
  assign rise_ok  = tick_rise && !tick_fall && !sclk_q;

  // Next-state, SPI pin and byte-hand-off logic
  always_comb begin
    state_d     = state_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cmd_sr_d    = cmd_sr_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    rx_cnt_d    = rx_cnt_q;
    remaining_d = remaining_q;
    hold_load   = 1'b0;
    byte_done   = 1'b0;
    byte_now    = rx_sr_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.start_len != '0) begin
            cmd_sr_d    = {READ_CMD, bus.start_addr};
            remaining_d = bus.start_len;
            cs_n_d      = 1'b0;
            mosi_d      = READ_CMD[7];
            busy_d      = 1'b1;
            bit_cnt_d   = 6'd0;
            rx_cnt_d    = 4'd0;
            state_d     = ST_CMD;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ST_CMD: begin
        if (bit_edge) begin
          sclk_d    = 1'b0;
          cmd_sr_d  = cmd_sr_q << 1;
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == LAST_CMD_BIT) begin
            mosi_d  = 1'b0;
            state_d = ST_DATA;
          end else begin
            mosi_d = cmd_sr_q[CMD_BITS-2];
          end
        end else if (rise_ok) begin
          sclk_d = 1'b1;
        end
      end

      ST_DATA: begin
        if (bit_edge) begin
          sclk_d    = 1'b0;
          byte_now  = {rx_sr_q[6:0], spi_miso};
          rx_sr_d   = byte_now;
          rx_cnt_d  = rx_cnt_q + 4'd1;
          byte_done = (rx_cnt_q == BYTE_FULL - 4'd1);
        end else begin
          byte_done = (rx_cnt_q == BYTE_FULL);
          if (rise_ok && !byte_done) begin
            sclk_d = 1'b1;
          end
        end
        if (byte_done && hold_can_load) begin
          hold_load   = 1'b1;
          rx_cnt_d    = 4'd0;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        sclk_d = 1'b0;
        if (tick_rise && !tick_fall) begin
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and SPI pin registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_sr_q    <= '0;
      bit_cnt_q   <= 6'd0;
      rx_sr_q     <= 8'h00;
      rx_cnt_q    <= 4'd0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_sr_q    <= cmd_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      rx_cnt_q    <= rx_cnt_d;
      remaining_q <= remaining_d;
    end
  end

  spi_byte_holding_reg u_hold (
    .clk_in    (clk_in),
    .rst       (rst),
    .load      (hold_load),
    .load_data (byte_now),
    .ready     (bus.data_ready),
    .data      (hold_data),
    .full      (hold_full),
    .can_load  (hold_can_load)
  );

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.data_out   = hold_data;
  assign bus.data_valid = hold_full;
  assign spi_cs_n       = cs_n_q;
  assign spi_sclk       = sclk_q;
  assign spi_mosi       = mosi_q;

endmodule

// File: tb/tb_spi_flash_stream_reader.sv
// Directed bench for the SPI flash stream reader: divide-by-4 tick source,
// behavioural READ-only flash on the SPI pins and a stream-side recorder.
module tb_spi_flash_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] tcnt = 2'd0;
  logic       tick_rise;
  logic       tick_fall;
  logic       spi_cs_n;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       miso_r = 1'b0;

  int checks = 0;
  int passed = 0;

  spi_flash_stream_reader_if #(.ADDR_W(24), .LEN_W(16)) bus ();

  spi_flash_stream_reader #(
    .ADDR_W   (24),
    .LEN_W    (16),
    .READ_CMD (8'h03)
  ) dut (
    .clk_in    (clk),
    .rst       (rst),
    .tick_rise (tick_rise),
    .tick_fall (tick_fall),
    .bus       (bus),
    .spi_cs_n  (spi_cs_n),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (miso_r)
  );

  always #5 clk = ~clk;

  // Divider with Power=1: rise strobe at phase 0, fall strobe at phase 2
  always @(posedge clk) tcnt <= tcnt + 2'd1;
  assign tick_rise = (tcnt == 2'd0);
  assign tick_fall = (tcnt == 2'd2);

  // Flash contents: simple address hash
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // Flash model: shifts in the command on rising SCLK, drives data on falling SCLK
  logic [31:0] fl_cmd = 32'h0;
  int          fl_rises = 0;
  int          fl_k;
  logic [7:0]  fl_b;
  int          sclk_pulses = 0;

  always @(posedge spi_sclk or posedge spi_cs_n) begin
    if (spi_cs_n) begin
      fl_rises <= 0;
    end else begin
      if (fl_rises < 32) fl_cmd <= {fl_cmd[30:0], spi_mosi};
      fl_rises <= fl_rises + 1;
    end
  end

  always @(negedge spi_sclk) begin
    if (!spi_cs_n && fl_rises >= 32) begin
      fl_k = fl_rises - 32;
      fl_b = flash_byte(fl_cmd[23:0] + 24'(fl_k / 8));
      miso_r <= fl_b[7 - (fl_k % 8)];
    end
  end

  always @(posedge spi_sclk) sclk_pulses <= sclk_pulses + 1;

  // Stream recorder and activity counters, sampled mid-cycle
  logic [7:0] got[$];
  int done_cycles = 0;
  int busy_cycles = 0;
  int cs_low_cycles = 0;

  always @(negedge clk) begin
    if (bus.done) done_cycles <= done_cycles + 1;
    if (bus.busy) busy_cycles <= busy_cycles + 1;
    if (!spi_cs_n) cs_low_cycles <= cs_low_cycles + 1;
    if (!rst && bus.data_valid && bus.data_ready) got.push_back(bus.data_out);
  end

  task automatic do_start(input logic [23:0] a, input logic [15:0] l);
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.start_addr = a;
    bus.start_len  = l;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (found == 0) $display("[TB] FAIL %s_done_timeout: done not seen within %0d cycles", name, budget);
    else passed++;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.data_valid) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (found == 0) $display("[TB] FAIL %s_valid_timeout: data_valid not seen within %0d cycles", name, budget);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (spi_cs_n !== 1'b1) $display("[TB] FAIL reset_cs_n: got %b want 1", spi_cs_n); else passed++;
    checks++; if (spi_sclk !== 1'b0) $display("[TB] FAIL reset_sclk: got %b want 0", spi_sclk); else passed++;
    checks++; if (spi_mosi !== 1'b0) $display("[TB] FAIL reset_mosi: got %b want 0", spi_mosi); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", bus.done); else passed++;
    checks++; if (bus.data_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", bus.data_valid); else passed++;
    checks++; if (bus.data_out !== 8'h00) $display("[TB] FAIL reset_data: got %h want 00", bus.data_out); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic_read();
    logic [7:0] exp_bytes [4];
    int base, p0, d0;
    exp_bytes = '{8'h3D, 8'h3E, 8'h3F, 8'h30};
    bus.data_ready = 1'b1;
    base = got.size();
    p0 = sclk_pulses;
    d0 = done_cycles;
    do_start(24'h012345, 16'd4);
    checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL basic_busy: got %b want 1", bus.busy); else passed++;
    checks++; if (spi_cs_n !== 1'b0) $display("[TB] FAIL basic_cs_low: got %b want 0", spi_cs_n); else passed++;
    wait_done(1000, "basic");
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) $display("[TB] FAIL basic_done_width: got %b want 0", bus.done); else passed++;
    checks++; if (spi_cs_n !== 1'b1) $display("[TB] FAIL basic_cs_high: got %b want 1", spi_cs_n); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL basic_busy_end: got %b want 0", bus.busy); else passed++;
    repeat (3) @(negedge clk);
    checks++; if (fl_cmd !== 32'h03012345) $display("[TB] FAIL basic_mosi_cmd: got %h want 03012345", fl_cmd); else passed++;
    checks++; if (sclk_pulses - p0 !== 64) $display("[TB] FAIL basic_sclk_pulses: got %0d want 64", sclk_pulses - p0); else passed++;
    checks++; if (done_cycles - d0 !== 1) $display("[TB] FAIL basic_done_count: got %0d want 1", done_cycles - d0); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got.size() <= base + i) $display("[TB] FAIL basic_byte%0d: missing want %h", i, exp_bytes[i]);
      else if (got[base + i] !== exp_bytes[i]) $display("[TB] FAIL basic_byte%0d: got %h want %h", i, got[base + i], exp_bytes[i]);
      else passed++;
    end
  endtask

  task automatic test_zero_len();
    int c0, b0, d0;
    c0 = cs_low_cycles;
    b0 = busy_cycles;
    d0 = done_cycles;
    do_start(24'h000100, 16'd0);
    checks++; if (bus.done !== 1'b1) $display("[TB] FAIL zero_done: got %b want 1", bus.done); else passed++;
    @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b0) $display("[TB] FAIL zero_done_width: got %b want 0", bus.done); else passed++;
    repeat (4) @(negedge clk);
    checks++; if (cs_low_cycles - c0 !== 0) $display("[TB] FAIL zero_cs_activity: got %0d want 0", cs_low_cycles - c0); else passed++;
    checks++; if (busy_cycles - b0 !== 0) $display("[TB] FAIL zero_busy: got %0d want 0", busy_cycles - b0); else passed++;
    checks++; if (done_cycles - d0 !== 1) $display("[TB] FAIL zero_done_count: got %0d want 1", done_cycles - d0); else passed++;
  endtask

  task automatic test_backpressure();
    int base, p0;
    logic [23:0] a;
    a = 24'h00A000;
    bus.data_ready = 1'b0;
    base = got.size();
    p0 = sclk_pulses;
    do_start(a, 16'd3);
    wait_valid(1000, "bp");
    @(posedge clk);
    repeat (34) @(posedge clk);
    #1;
    checks++; if (spi_sclk !== 1'b0) $display("[TB] FAIL bp_sclk_stalled: got %b want 0", spi_sclk); else passed++;
    checks++; if (bus.data_valid !== 1'b1) $display("[TB] FAIL bp_valid_held: got %b want 1", bus.data_valid); else passed++;
    checks++; if (bus.data_out !== flash_byte(a)) $display("[TB] FAIL bp_byte1_held: got %h want %h", bus.data_out, flash_byte(a)); else passed++;
    repeat (4) @(posedge clk);
    #1;
    bus.data_ready = 1'b1;
    wait_done(1000, "bp");
    repeat (4) @(negedge clk);
    checks++; if (sclk_pulses - p0 !== 56) $display("[TB] FAIL bp_sclk_pulses: got %0d want 56", sclk_pulses - p0); else passed++;
    checks++; if (got.size() - base !== 3) $display("[TB] FAIL bp_count: got %0d want 3", got.size() - base); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got.size() <= base + i) $display("[TB] FAIL bp_byte%0d: missing want %h", i, flash_byte(a + 24'(i)));
      else if (got[base + i] !== flash_byte(a + 24'(i))) $display("[TB] FAIL bp_byte%0d: got %h want %h", i, got[base + i], flash_byte(a + 24'(i)));
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [23:0] a;
    bus.data_ready = 1'b0;
    do_start(24'h123456, 16'd8);
    wait_valid(1000, "rstmid");
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (spi_cs_n !== 1'b1) $display("[TB] FAIL rstmid_cs_n: got %b want 1", spi_cs_n); else passed++;
    checks++; if (bus.data_valid !== 1'b0) $display("[TB] FAIL rstmid_valid: got %b want 0", bus.data_valid); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (spi_sclk !== 1'b0) $display("[TB] FAIL rstmid_sclk: got %b want 0", spi_sclk); else passed++;
    rst = 1'b0;
    bus.data_ready = 1'b1;
    repeat (2) @(posedge clk);
    a = 24'h0000F0;
    base = got.size();
    do_start(a, 16'd2);
    wait_done(1000, "rstmid");
    repeat (4) @(negedge clk);
    checks++; if (fl_cmd !== {8'h03, a}) $display("[TB] FAIL rstmid_cmd: got %h want %h", fl_cmd, {8'h03, a}); else passed++;
    checks++; if (got.size() - base !== 2) $display("[TB] FAIL rstmid_count: got %0d want 2", got.size() - base); else passed++;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got.size() <= base + i) $display("[TB] FAIL rstmid_byte%0d: missing want %h", i, flash_byte(a + 24'(i)));
      else if (got[base + i] !== flash_byte(a + 24'(i))) $display("[TB] FAIL rstmid_byte%0d: got %h want %h", i, got[base + i], flash_byte(a + 24'(i)));
      else passed++;
    end
  endtask

  task automatic test_start_while_busy();
    int base, p0;
    logic [23:0] a;
    a = 24'h3C0A11;
    bus.data_ready = 1'b1;
    base = got.size();
    p0 = sclk_pulses;
    do_start(a, 16'd2);
    repeat (20) @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.start_addr = 24'hABCDEF;
    bus.start_len  = 16'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL busy_start_busy: got %b want 1", bus.busy); else passed++;
    wait_done(1000, "busy_start");
    repeat (4) @(negedge clk);
    checks++; if (fl_cmd !== {8'h03, a}) $display("[TB] FAIL busy_start_cmd: got %h want %h", fl_cmd, {8'h03, a}); else passed++;
    checks++; if (sclk_pulses - p0 !== 48) $display("[TB] FAIL busy_start_pulses: got %0d want 48", sclk_pulses - p0); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL busy_start_idle: got %b want 0", bus.busy); else passed++;
    checks++; if (got.size() - base !== 2) $display("[TB] FAIL busy_start_count: got %0d want 2", got.size() - base); else passed++;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got.size() <= base + i) $display("[TB] FAIL busy_start_byte%0d: missing want %h", i, flash_byte(a + 24'(i)));
      else if (got[base + i] !== flash_byte(a + 24'(i))) $display("[TB] FAIL busy_start_byte%0d: got %h want %h", i, got[base + i], flash_byte(a + 24'(i)));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [23:0] a;
    a = 24'h7F00FE;
    bus.data_ready = 1'b0;
    base = got.size();
    do_start(a, 16'd3);
    wait_valid(1000, "b2b");
    @(posedge clk);
    repeat (30) @(posedge clk);
    #1;
    bus.data_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.data_ready = 1'b0;
    checks++; if (bus.data_valid !== 1'b1) $display("[TB] FAIL b2b_valid: got %b want 1", bus.data_valid); else passed++;
    checks++; if (bus.data_out !== flash_byte(a + 24'd1)) $display("[TB] FAIL b2b_byte2: got %h want %h", bus.data_out, flash_byte(a + 24'd1)); else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (spi_sclk !== 1'b1) $display("[TB] FAIL b2b_no_stall: got %b want 1", spi_sclk); else passed++;
    bus.data_ready = 1'b1;
    wait_done(1000, "b2b");
    repeat (4) @(negedge clk);
    checks++; if (got.size() - base !== 3) $display("[TB] FAIL b2b_count: got %0d want 3", got.size() - base); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got.size() <= base + i) $display("[TB] FAIL b2b_byte%0d: missing want %h", i, flash_byte(a + 24'(i)));
      else if (got[base + i] !== flash_byte(a + 24'(i))) $display("[TB] FAIL b2b_byte%0d: got %h want %h", i, got[base + i], flash_byte(a + 24'(i)));
      else passed++;
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.start_addr = 24'h0;
    bus.start_len  = 16'd0;
    bus.data_ready = 1'b0;
    test_reset();
    test_basic_read();
    test_zero_len();
    test_backpressure();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
